// File: rtl/button_pkg.sv
// ----------------------------------------------------------------------------
// button_pkg : shared state type and default timing for the button path
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package button_pkg;

   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      IDLE     = 2'd1,
      PRESS    = 2'd2,
      HOLD     = 2'd3
   } btn_state_t;

   localparam int DEF_LONG_CYCLES   = 25_000_000;
   localparam int DEF_REPEAT_CYCLES = 5_000_000;

endpackage : button_pkg

`default_nettype wire

// File: rtl/button_event_fsm.sv
// ----------------------------------------------------------------------------
// button_event_fsm : turns a debounced button level into one-cycle events
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module button_event_fsm
   import button_pkg::*;
#(
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter bit REPEAT_EN     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic click_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam int CNT_W = $clog2((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES);
   localparam logic [CNT_W-1:0] c_LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   btn_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             click_q, click_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;
   logic             held_q, held_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      click_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         WAIT_REL: begin
            if (!btn_level) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (btn_level) begin
               state_d = PRESS;
               cnt_d   = '0;
               press_d = 1'b1;
            end
         end
         PRESS: begin
            // Release wins over the long threshold on the same edge.
            if (!btn_level) begin
               state_d   = IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
               click_d   = 1'b1;
            end else if (cnt_q == c_LONG_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (!btn_level) begin
               state_d   = IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
            end else if (REPEAT_EN) begin
               if (cnt_q == c_REPEAT_LAST) begin
                  cnt_d    = '0;
                  repeat_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = '0;
            end
         end
         default: begin
            state_d = WAIT_REL;
            cnt_d   = '0;
         end
      endcase
      held_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= WAIT_REL;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         click_q   <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         click_q   <= click_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         held_q    <= held_d;
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign click_pulse   = click_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = repeat_q;
   assign held          = held_q;

endmodule : button_event_fsm

`default_nettype wire
